wb_pic: RTL and testbench

Wishbone-slave programmable interrupt controller that drives the `irq_req`/`irq_vec`/`irq_ack` handshake of the CPU bus interface. It sits on one port of the peripheral arbiter, alongside uart/spi/timer. It collects up to 32 interrupt lines (timer, uart, spi, `eth_int`, …) and latches edge or level requests. It masks them, selects the highest-priority pending source and presents its autovector until the CPU acknowledges.

---
 rtl/wb_pic.sv | 272 +++++++++++++++++++++++++++
 tb/tb_wb_pic.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_pic.sv
// wb_pic: Wishbone-slave programmable interrupt controller. It latches edge or
//   level requests, masks them, and presents the autovector of the
//   highest-priority pending source to the CPU until that vector is acknowledged.
// Latency: irq_src sampled at edge k -> pending at k+1 -> irq_req at k+2.
//   With WB_PIC_SYNC_EN defined, a 2-flop synchroniser adds 2 cycles.
//   Bus: ack_o rises one cycle after the strobe.
// Backpressure: the bus is never stalled. ack_o is a 1-cycle pulse, so an
//   access takes at least 2 cycles. The vector is held until irq_ack arrives
//   or the request is withdrawn.
//
// Optional feature macro: WB_PIC_SYNC_EN (adds an input synchroniser for async pins).
//
// Ports:
//   clk_i, rst_i          system clock, synchronous active-high reset
//   cyc_i, stb_i, we_i    Wishbone cycle / strobe / write enable
//   adr_i[29:0]           word address; only [1:0] selects a register
//   sel_i[3:0], dat_i     byte lanes and write data
//   ack_o, dat_o          Wishbone acknowledge and registered read data
//   irq_src[SOURCES-1:0]  active-high interrupt lines
//   irq_req, irq_vec      request and autovector to the CPU interface
//   irq_ack               1-cycle pulse: the CPU has taken the vector
//
// Register map (by adr_i[1:0]):
//   0 PENDING  read pending bits; write 1 clears an edge-mode bit
//   1 ENABLE   1 = source enabled
//   2 EDGE     1 = rising-edge latched, 0 = level
//   3 STATUS   {irq_req, 18'b0, latched index[4:0], irq_vec[7:0]}, read-only
module wb_pic #(
  parameter int          SOURCES  = 8,
  parameter logic [7:0]  VEC_BASE = 8'd64
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               cyc_i,
  input  logic               stb_i,
  input  logic               we_i,
  input  logic [29:0]        adr_i,
  input  logic [3:0]         sel_i,
  input  logic [31:0]        dat_i,
  output logic               ack_o,
  output logic [31:0]        dat_o,
  input  logic [SOURCES-1:0] irq_src,
  output logic               irq_req,
  output logic [7:0]         irq_vec,
  input  logic               irq_ack
);

  // Bits at or above SOURCES never hold state and always read as 0.
  localparam logic [31:0] SRC_MASK = (SOURCES >= 32) ? 32'hFFFF_FFFF
                                                     : ((32'd1 << SOURCES) - 32'd1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t      state;
  logic [4:0]  lat_idx;

  logic [31:0] pending;
  logic [31:0] enable;
  logic [31:0] edge_sel;
  logic [31:0] smp;
  logic [31:0] smp_prev;

  logic [31:0] src_ext;
  logic [31:0] src_in;

  // Only the low two address bits decode a register.
  logic unused_adr;
  assign unused_adr = ^adr_i[29:2];

  assign src_ext = 32'(irq_src);

  // ---------------------------------------------------------------------------
  // Input conditioning
  // ---------------------------------------------------------------------------
`ifdef WB_PIC_SYNC_EN
  // The two extra flops ahead of the sample register resolve metastability
  // on asynchronous pins such as eth_int.
  logic [31:0] sync1;
  logic [31:0] sync2;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= src_ext & SRC_MASK;
      sync2 <= sync1;
    end
  end

  assign src_in = sync2;
`else
  assign src_in = src_ext;
`endif

  // smp_prev holds the sample from one cycle earlier, for rising-edge detection.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      smp      <= '0;
      smp_prev <= '0;
    end else begin
      smp      <= src_in & SRC_MASK;
      smp_prev <= smp;
    end
  end

  // ---------------------------------------------------------------------------
  // Wishbone decode
  // ---------------------------------------------------------------------------
  logic        wb_acc;
  logic        wb_wr;
  logic [1:0]  reg_sel;
  logic [31:0] byte_mask;

  assign wb_acc    = cyc_i & stb_i & ~ack_o;
  assign wb_wr     = wb_acc & we_i;
  assign reg_sel   = adr_i[1:0];
  assign byte_mask = {{8{sel_i[3]}}, {8{sel_i[2]}}, {8{sel_i[1]}}, {8{sel_i[0]}}};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ack_o <= 1'b0;
    end else begin
      ack_o <= cyc_i & stb_i & ~ack_o;
    end
  end

  // ---------------------------------------------------------------------------
  // Pending / enable / edge registers
  // ---------------------------------------------------------------------------
  logic [31:0] w1c_bits;
  logic [31:0] ack_bits;
  logic [31:0] edge_set;
  logic [31:0] edge_pend;
  logic [31:0] pending_nxt;

  always_comb begin
    w1c_bits = '0;
    if (wb_wr && (reg_sel == 2'd0)) begin
      w1c_bits = dat_i & byte_mask;
    end

    // The acknowledged source is cleared in the same edge that the FSM
    // moves to HOLD.
    ack_bits = '0;
    if ((state == S_REQ) && irq_ack) begin
      ack_bits = 32'd1 << lat_idx;
    end

    edge_set = smp & ~smp_prev;

    // The set term is ORed in after the clear, so a new edge that coincides
    // with a clear leaves the bit pending.
    edge_pend = (pending & ~(w1c_bits | ack_bits)) | edge_set;

    // Level bits simply follow the sample register. When EDGE flips 0->1,
    // the bit keeps its current value and edge mode takes over from there.
    pending_nxt = ((edge_sel & edge_pend) | (~edge_sel & smp)) & SRC_MASK;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending  <= '0;
      enable   <= '0;
      edge_sel <= '0;
    end else begin
      pending <= pending_nxt;
      if (wb_wr && (reg_sel == 2'd1)) begin
        enable <= ((enable & ~byte_mask) | (dat_i & byte_mask)) & SRC_MASK;
      end
      if (wb_wr && (reg_sel == 2'd2)) begin
        edge_sel <= ((edge_sel & ~byte_mask) | (dat_i & byte_mask)) & SRC_MASK;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------------
  logic [31:0] rd_dat;

  always_comb begin
    rd_dat = '0;
    case (reg_sel)
      2'd0:    rd_dat = pending;
      2'd1:    rd_dat = enable;
      2'd2:    rd_dat = edge_sel;
      default: rd_dat = {irq_req, 18'd0, lat_idx, irq_vec};
    endcase
  end

  // The read value reflects the state before the edge that raises ack_o.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dat_o <= '0;
    end else if (wb_acc && !we_i) begin
      dat_o <= rd_dat;
    end
  end

  // ---------------------------------------------------------------------------
  // Priority select: the lowest index wins
  // ---------------------------------------------------------------------------
  logic [31:0] active;
  logic        cand_vld;
  logic [4:0]  cand_idx;
  logic        lat_live;

  always_comb begin
    active   = pending & enable;
    cand_vld = 1'b0;
    cand_idx = '0;
    // Scanning downward lets the lowest set index be written last.
    for (int i = 31; i >= 0; i--) begin
      if (active[i]) begin
        cand_vld = 1'b1;
        cand_idx = 5'(i);
      end
    end
  end

  assign lat_live = pending[lat_idx] & enable[lat_idx];

  // ---------------------------------------------------------------------------
  // Request FSM
  // ---------------------------------------------------------------------------
  // REQ freezes the vector. A higher-priority arrival waits until HOLD has
  // passed, so the CPU never sees the vector change under an active request.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= S_IDLE;
      irq_req <= 1'b0;
      irq_vec <= VEC_BASE;
      lat_idx <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cand_vld) begin
            lat_idx <= cand_idx;
            irq_vec <= VEC_BASE + {3'b000, cand_idx};
            irq_req <= 1'b1;
            state   <= S_REQ;
          end
        end
        S_REQ: begin
          // An ack takes priority over a withdrawal in the same cycle.
          if (irq_ack) begin
            irq_req <= 1'b0;
            state   <= S_HOLD;
          end else if (!lat_live) begin
            irq_req <= 1'b0;
            state   <= S_IDLE;
          end
        end
        S_HOLD: begin
          // One quiet cycle so the cleared pending bit is visible before
          // the next arbitration.
          state <= S_IDLE;
        end
        default: begin
          irq_req <= 1'b0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_pic.sv
// tb_wb_pic: directed bench for wb_pic. Expected values are queued when
//   stimulus is applied and popped when the DUT output is observed.
// Timing: inputs are driven and outputs sampled 1 ns after each rising edge.
module tb_wb_pic;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc, stb, we;
  logic [29:0] adr;
  logic [3:0]  sel;
  logic [31:0] wdat;
  logic        ack_o;
  logic [31:0] dat_o;
  logic [7:0]  irq_src;
  logic        irq_req;
  logic [7:0]  irq_vec;
  logic        irq_ack;

  int ncomp = 0;
  int nfail = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  wb_pic #(.SOURCES(8), .VEC_BASE(8'd64)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .cyc_i   (cyc),
    .stb_i   (stb),
    .we_i    (we),
    .adr_i   (adr),
    .sel_i   (sel),
    .dat_i   (wdat),
    .ack_o   (ack_o),
    .dat_o   (dat_o),
    .irq_src (irq_src),
    .irq_req (irq_req),
    .irq_vec (irq_vec),
    .irq_ack (irq_ack)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: observed no finish, required finish before 400000");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input string t, input logic [31:0] e);
    exp_q.push_back(e);
    tag_q.push_back(t);
  endtask

  task automatic check(input logic [31:0] obs);
    logic [31:0] e;
    string       t;
    ncomp++;
    if (exp_q.size() == 0) begin
      nfail++;
      $error("FAIL sb_underflow: observed %h required a queued value", obs);
      return;
    end
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    assert (obs === e) else begin
      nfail++;
      $error("FAIL %s: observed %h required %h", t, obs, e);
    end
  endtask

  task automatic check_now(input string t, input logic [31:0] obs, input logic [31:0] e);
    push_exp(t, e);
    check(obs);
  endtask

  task automatic timeout_fail(input string t);
    ncomp++;
    nfail++;
    $error("FAIL %s: observed no ack_o within 4 cycles, required ack_o", t);
  endtask

  task automatic bus_read(input logic [1:0] a, input logic [31:0] e, input string t);
    bit got;
    push_exp(t, e);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 30'(a); sel = 4'hF;
    got = 1'b0;
    for (int n = 0; n < 4 && !got; n++) begin
      tick();
      if (ack_o) got = 1'b1;
    end
    cyc = 1'b0; stb = 1'b0;
    if (got) begin
      check(dat_o);
    end else begin
      exp_q.pop_front();
      tag_q.pop_front();
      timeout_fail(t);
    end
    tick();
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] s);
    bit got;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 30'(a); sel = s; wdat = d;
    got = 1'b0;
    for (int n = 0; n < 4 && !got; n++) begin
      tick();
      if (ack_o) got = 1'b1;
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    if (!got) timeout_fail("wr_ack");
    tick();
  endtask

  // A one-cycle pulse on source n, then wait until the request is expected.
  task automatic pulse_src(input int n);
    irq_src[n] = 1'b1;
    tick();
    irq_src[n] = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; sel = '0; wdat = '0;
    irq_src = '0; irq_ack = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check_now("rst_irq_req", 32'(irq_req), 32'd0);
    check_now("rst_irq_vec", 32'(irq_vec), 32'h40);
    bus_read(2'd0, 32'h0, "rst_pending");
    bus_read(2'd1, 32'h0, "rst_enable");
    bus_read(2'd2, 32'h0, "rst_edge");
    bus_read(2'd3, 32'h40, "rst_status");

    // Register masking, byte lanes, read-only STATUS
    bus_write(2'd1, 32'hFFFF_FFFF, 4'hF);
    bus_read(2'd1, 32'h0000_00FF, "enable_mask");
    bus_write(2'd2, 32'h5A5A_5A5A, 4'b0001);
    bus_read(2'd2, 32'h0000_005A, "edge_lane0");
    bus_write(2'd2, 32'h0000_0000, 4'b0010);
    bus_read(2'd2, 32'h0000_005A, "edge_lane1_only");
    bus_write(2'd3, 32'hFFFF_FFFF, 4'hF);
    bus_read(2'd3, 32'h0000_0040, "status_ro");
    bus_write(2'd1, 32'h0, 4'hF);
    bus_write(2'd2, 32'h0, 4'hF);

    // Edge source 0: latency, vector, ack
    bus_write(2'd1, 32'h05, 4'hF);
    bus_write(2'd2, 32'h01, 4'hF);
    irq_src[0] = 1'b1;
    tick();                        // sample edge k
    irq_src[0] = 1'b0;
    tick();                        // pending at k+1
    check_now("e0_req_k1", 32'(irq_req), 32'd0);
    tick();                        // request at k+2
    check_now("e0_req_k2", 32'(irq_req), 32'd1);
    check_now("e0_vec", 32'(irq_vec), 32'h40);
    bus_read(2'd3, 32'h8000_0040, "e0_status");
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    check_now("e0_ack_drop", 32'(irq_req), 32'd0);
    bus_read(2'd0, 32'h0, "e0_pending_clr");
    check_now("e0_no_rereq", 32'(irq_req), 32'd0);

    // Level source 2: re-request exactly 3 cycles after the ack
    bus_write(2'd2, 32'h00, 4'hF);
    bus_write(2'd1, 32'h04, 4'hF);
    irq_src[2] = 1'b1;
    tick();
    tick();
    check_now("l2_req_k1", 32'(irq_req), 32'd0);
    tick();
    check_now("l2_req_k2", 32'(irq_req), 32'd1);
    check_now("l2_vec", 32'(irq_vec), 32'h42);
    irq_ack = 1'b1;
    tick();                        // a+1
    irq_ack = 1'b0;
    check_now("l2_a1", 32'(irq_req), 32'd0);
    tick();                        // a+2
    check_now("l2_a2", 32'(irq_req), 32'd0);
    tick();                        // a+3
    check_now("l2_a3", 32'(irq_req), 32'd1);
    check_now("l2_a3_vec", 32'(irq_vec), 32'h42);
    irq_src[2] = 1'b0;
    for (int n = 0; n < 6; n++) tick();
    check_now("l2_withdrawn", 32'(irq_req), 32'd0);
    bus_read(2'd0, 32'h0, "l2_pending_low");

    // Vector frozen in REQ while a higher-priority source arrives
    bus_write(2'd2, 32'h0A, 4'hF);
    bus_write(2'd1, 32'h0A, 4'hF);
    pulse_src(3);
    tick();
    check_now("p3_req", 32'(irq_req), 32'd1);
    check_now("p3_vec", 32'(irq_vec), 32'h43);
    pulse_src(1);
    tick();
    tick();
    check_now("p3_frozen_req", 32'(irq_req), 32'd1);
    check_now("p3_frozen_vec", 32'(irq_vec), 32'h43);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    check_now("p3_ack_drop", 32'(irq_req), 32'd0);
    tick();
    tick();
    check_now("p1_req", 32'(irq_req), 32'd1);
    check_now("p1_vec", 32'(irq_vec), 32'h41);
    bus_read(2'd3, 32'h8000_0141, "p1_status");
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    for (int n = 0; n < 4; n++) tick();
    check_now("p1_done", 32'(irq_req), 32'd0);

    // W1C together with the ack: the ack is honoured, no re-request
    bus_write(2'd2, 32'h01, 4'hF);
    bus_write(2'd1, 32'h01, 4'hF);
    pulse_src(0);
    tick();
    check_now("c0_req", 32'(irq_req), 32'd1);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 30'd0; sel = 4'hF; wdat = 32'h1;
    irq_ack = 1'b1;
    tick();
    check_now("c0_wr_ack", 32'(ack_o), 32'd1);
    cyc = 1'b0; stb = 1'b0; we = 1'b0; irq_ack = 1'b0;
    check_now("c0_drop", 32'(irq_req), 32'd0);
    for (int n = 0; n < 4; n++) tick();
    check_now("c0_no_rereq", 32'(irq_req), 32'd0);
    bus_read(2'd0, 32'h0, "c0_pending");

    // W1C alone withdraws one edge after the write commits
    pulse_src(0);
    tick();
    check_now("w0_req", 32'(irq_req), 32'd1);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 30'd0; sel = 4'hF; wdat = 32'h1;
    tick();                        // write commits
    check_now("w0_wr_ack", 32'(ack_o), 32'd1);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    check_now("w0_still_req", 32'(irq_req), 32'd1);
    tick();
    check_now("w0_withdrawn", 32'(irq_req), 32'd0);
    check_now("w0_ack_pulse", 32'(ack_o), 32'd0);

    // A new edge and a W1C of the same bit in one cycle: set wins
    bus_write(2'd1, 32'h00, 4'hF);
    irq_src[0] = 1'b1;
    tick();                        // sample edge k
    irq_src[0] = 1'b0;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 30'd0; sel = 4'hF; wdat = 32'h1;
    tick();                        // k+1: set and clear together
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    tick();
    bus_read(2'd0, 32'h1, "sw_set_wins");

    // Reset while in REQ
    bus_write(2'd1, 32'h01, 4'hF);
    check_now("r_req", 32'(irq_req), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_now("r_req_drop", 32'(irq_req), 32'd0);
    check_now("r_vec", 32'(irq_vec), 32'h40);
    bus_read(2'd0, 32'h0, "r_pending");
    bus_read(2'd1, 32'h0, "r_enable");
    bus_read(2'd2, 32'h0, "r_edge");
    bus_read(2'd3, 32'h40, "r_status");

    assert (exp_q.size() == 0) else begin
      nfail++;
      $error("FAIL sb_leftover: observed %0d queued required 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule
